// File: rtl/sobel_pipe.sv
// sobel_pipe: three-stage pipelined Sobel gradient unit with selectable magnitude mode,
// quantised direction, valid/ready backpressure and a saturating edge-pixel counter.
module sobel_pipe #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned COUNT_W = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9*PIX_W-1:0]   win_data,
    input  logic                 win_valid,
    output logic                 win_ready,
    input  logic [1:0]           mode,
    input  logic [OUT_W-1:0]     threshold,
    output logic [OUT_W-1:0]     mag_data,
    output logic [1:0]           mag_dir,
    output logic                 mag_valid,
    input  logic                 mag_ready,
    input  logic                 count_clear,
    output logic [COUNT_W-1:0]   edge_count
);
    localparam int unsigned GW = PIX_W + 3;
    localparam int unsigned AW = PIX_W + 2;
    localparam int unsigned CW = (GW > OUT_W) ? GW : OUT_W;

    typedef enum logic [1:0] {
        MODE_L1      = 2'd0,
        MODE_MAX     = 2'd1,
        MODE_MAXHALF = 2'd2,
        MODE_THRESH  = 2'd3
    } mode_e;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [OUT_W-1:0] clamp(input logic [GW-1:0] v);
        logic [CW-1:0] e;
        logic [CW-1:0] lim;
        e              = CW'(v);
        lim            = '0;
        lim[OUT_W-1:0] = '1;
        return (e > lim) ? lim[OUT_W-1:0] : e[OUT_W-1:0];
    endfunction

    logic                    w_adv;
    logic [PIX_W-1:0]        w_p [9];
    logic                    w_unused_center;
    logic signed [GW-1:0]    w_gx, w_gy;
    logic [AW-1:0]           w_ax, w_ay;
    logic [1:0]              w_dir;
    logic [AW-1:0]           w_mx, w_mn;
    logic [GW-1:0]           w_l1, w_mh;
    logic [OUT_W-1:0]        w_l1c;
    logic                    w_edge;
    logic [OUT_W-1:0]        w_mag;

    logic                    r_v1, r_v2, r_v3;
    logic signed [GW-1:0]    r_gx, r_gy;
    logic [1:0]              r_m1, r_m2;
    logic [OUT_W-1:0]        r_t1, r_t2;
    logic [AW-1:0]           r_ax, r_ay;
    logic [1:0]              r_dir2, r_dir3;
    logic [OUT_W-1:0]        r_mag;
    logic                    r_edge3;
    logic [COUNT_W-1:0]      r_cnt;

    // Whole pipeline moves in lockstep, so bubbles are preserved under stall.
    assign w_adv     = !r_v3 || mag_ready;
    assign win_ready = w_adv;

    always_comb begin
        for (int unsigned k = 0; k < 9; k++) begin
            w_p[k] = win_data[k*PIX_W +: PIX_W];
        end
    end

    // The centre pixel carries zero weight in both kernels.
    assign w_unused_center = ^w_p[4];

    assign w_gx = (ext(w_p[2]) + (ext(w_p[5]) <<< 1) + ext(w_p[8]))
                - (ext(w_p[0]) + (ext(w_p[3]) <<< 1) + ext(w_p[6]));
    assign w_gy = (ext(w_p[6]) + (ext(w_p[7]) <<< 1) + ext(w_p[8]))
                - (ext(w_p[0]) + (ext(w_p[1]) <<< 1) + ext(w_p[2]));

    assign w_ax = AW'(r_gx[GW-1] ? -r_gx : r_gx);
    assign w_ay = AW'(r_gy[GW-1] ? -r_gy : r_gy);

    always_comb begin
        w_dir = 2'd0;
        if ({w_ay, 1'b0} <= {1'b0, w_ax}) begin
            w_dir = 2'd0;
        end else if ({w_ax, 1'b0} <= {1'b0, w_ay}) begin
            w_dir = 2'd2;
        end else if (r_gx[GW-1] == r_gy[GW-1]) begin
            w_dir = 2'd1;
        end else begin
            w_dir = 2'd3;
        end
    end

    assign w_mx   = (r_ax > r_ay) ? r_ax : r_ay;
    assign w_mn   = (r_ax > r_ay) ? r_ay : r_ax;
    assign w_l1   = GW'(r_ax) + GW'(r_ay);
    assign w_mh   = GW'(w_mx) + GW'(w_mn >> 1);
    assign w_l1c  = clamp(w_l1);
    assign w_edge = (w_l1c >= r_t2);

    always_comb begin
        w_mag = '0;
        case (mode_e'(r_m2))
            MODE_L1:      w_mag = w_l1c;
            MODE_MAX:     w_mag = clamp(GW'(w_mx));
            MODE_MAXHALF: w_mag = clamp(w_mh);
            MODE_THRESH:  w_mag = w_edge ? '1 : '0;
            default:      w_mag = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1    <= 1'b0;
            r_gx    <= '0;
            r_gy    <= '0;
            r_m1    <= '0;
            r_t1    <= '0;
            r_v2    <= 1'b0;
            r_ax    <= '0;
            r_ay    <= '0;
            r_dir2  <= '0;
            r_m2    <= '0;
            r_t2    <= '0;
            r_v3    <= 1'b0;
            r_mag   <= '0;
            r_dir3  <= '0;
            r_edge3 <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= win_valid;
            r_gx    <= w_gx;
            r_gy    <= w_gy;
            r_m1    <= mode;
            r_t1    <= threshold;
            r_v2    <= r_v1;
            r_ax    <= w_ax;
            r_ay    <= w_ay;
            r_dir2  <= w_dir;
            r_m2    <= r_m1;
            r_t2    <= r_t1;
            r_v3    <= r_v2;
            r_mag   <= w_mag;
            r_dir3  <= r_dir2;
            r_edge3 <= w_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (count_clear) begin
            r_cnt <= '0;
        end else if (r_v3 && mag_ready && r_edge3 && (r_cnt != '1)) begin
            r_cnt <= r_cnt + COUNT_W'(1);
        end
    end

    assign mag_valid  = r_v3;
    assign mag_data   = r_mag;
    assign mag_dir    = r_dir3;
    assign edge_count = r_cnt;

endmodule
